// File: rtl/pipelined_fetch_stage_if.sv
// Memory-fetch and downstream-stream signals of the fetch stage.
// The master side drives the address and offers words; the slave side answers and accepts.
interface pipelined_fetch_stage_if;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pipelined_fetch_stage.sv
// Fetches COUNT consecutive words from a combinational memory and streams them
// downstream through a 2-entry FIFO, with a done pulse after the last word leaves.
module pipelined_fetch_stage #(
    parameter logic [29:0] COUNT = 30'd8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    pipelined_fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [29:0] LAST_IDX = COUNT - 30'd1;

    state_t      state_q, state_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] fifo_q [2];
    logic [31:0] fifo_d [2];
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  occ_q, occ_d;
    logic        done_q, done_d;
    logic        pop;
    logic        issue;

    assign pop   = (occ_q != 2'd0) && bus.out_ready;
    // A full FIFO may still accept a word when its head leaves in the same cycle.
    assign issue = (state_q == FETCH) && ((occ_q != 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fifo_d  = fifo_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        occ_d   = occ_q;
        done_d  = 1'b0;

        if (issue) begin
            fifo_d[wr_q] = bus.mem_data;
            wr_d         = ~wr_q;
            idx_d        = idx_q + 30'd1;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({issue, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (COUNT == 30'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = 30'd0;
                    end
                end
            end
            FETCH: begin
                if (issue && (idx_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (occ_q == 2'd1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 30'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            occ_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                fifo_q[gi] <= 32'd0;
            end else begin
                fifo_q[gi] <= fifo_d[gi];
            end
        end
    end

    assign bus.mem_addr  = idx_q;
    assign bus.out_data  = fifo_q[rd_q];
    assign bus.out_valid = (occ_q != 2'd0);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_pipelined_fetch_stage.sv
// Directed bench for the fetch stage: four instances with COUNT 4, 8, 3 and 0,
// each fed mem_data = index*3 and observed through a selectable mux.
module tb_pipelined_fetch_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start_v = 4'd0;
    logic [3:0] ready_v = 4'd0;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    int         sel = 0;
    int         n_vec = 0;
    int         n_err = 0;

    logic [31:0] exp_words [8] = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd12, 32'd15, 32'd18, 32'd21};

    always #5 clk = ~clk;

    pipelined_fetch_stage_if b4 ();
    pipelined_fetch_stage_if b8 ();
    pipelined_fetch_stage_if b3 ();
    pipelined_fetch_stage_if b0 ();

    assign b4.mem_data  = {2'b00, b4.mem_addr} * 32'd3;
    assign b8.mem_data  = {2'b00, b8.mem_addr} * 32'd3;
    assign b3.mem_data  = {2'b00, b3.mem_addr} * 32'd3;
    assign b0.mem_data  = {2'b00, b0.mem_addr} * 32'd3;
    assign b4.out_ready = ready_v[0];
    assign b8.out_ready = ready_v[1];
    assign b3.out_ready = ready_v[2];
    assign b0.out_ready = ready_v[3];

    pipelined_fetch_stage #(.COUNT(30'd4)) u4 (.clk(clk), .reset(rst_n), .start(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .bus(b4.master));
    pipelined_fetch_stage #(.COUNT(30'd8)) u8 (.clk(clk), .reset(rst_n), .start(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .bus(b8.master));
    pipelined_fetch_stage #(.COUNT(30'd3)) u3 (.clk(clk), .reset(rst_n), .start(start_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .bus(b3.master));
    pipelined_fetch_stage #(.COUNT(30'd0)) u0 (.clk(clk), .reset(rst_n), .start(start_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .bus(b0.master));

    logic        obs_valid;
    logic [31:0] obs_data;
    logic [29:0] obs_addr;
    logic        obs_busy;
    logic        obs_done;

    always_comb begin
        obs_valid = b4.out_valid;
        obs_data  = b4.out_data;
        obs_addr  = b4.mem_addr;
        case (sel)
            1: begin obs_valid = b8.out_valid; obs_data = b8.out_data; obs_addr = b8.mem_addr; end
            2: begin obs_valid = b3.out_valid; obs_data = b3.out_data; obs_addr = b3.mem_addr; end
            3: begin obs_valid = b0.out_valid; obs_data = b0.out_data; obs_addr = b0.mem_addr; end
            default: ;
        endcase
        obs_busy = busy_v[sel[1:0]];
        obs_done = done_v[sel[1:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready=1, 1: ready=0 for five cycles, 2: ready toggles, 3: start held, 4: COUNT==0
    task automatic collect(input int n_exp, input int mode, input int max_cyc);
        int   n_got = 0;
        int   done_cnt = 0;
        int   done_c = -1;
        int   last_pop = -1;
        bit   busy_seen = 1'b0;
        logic rdy;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            start_v[sel] = (c == 0) || (mode == 3 && done_cnt == 0);
            case (mode)
                1:       rdy = (c >= 5);
                2:       rdy = (c % 2 == 1);
                default: rdy = 1'b1;
            endcase
            ready_v[sel] = rdy;
            #1;
            if (obs_busy) busy_seen = 1'b1;
            if (mode == 0 && n_exp > 0 && c == 1) begin
                check("first_cycle_valid", 32'(obs_valid), 0);
                check("addr_cleared", 32'(obs_addr), 0);
                check("busy_in_fetch", 32'(obs_busy), 1);
            end
            if (mode == 0 && n_exp > 0 && c == 2) check("latency_valid", 32'(obs_valid), 1);
            if (mode == 1 && c == 4) begin
                check("stall_addr", 32'(obs_addr), 2);
                check("stall_head", obs_data, 0);
                check("stall_valid", 32'(obs_valid), 1);
            end
            if (obs_valid && rdy) begin
                $display("sel=%0d cyc=%0d pop word%0d data=%0d", sel, c, n_got, obs_data);
                if (n_got < n_exp) check($sformatf("word%0d", n_got), obs_data, exp_words[n_got]);
                else check("word_overrun", n_got + 1, n_exp);
                n_got++;
                last_pop = c;
            end
            if (obs_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_c = c;
                    check("busy_at_done", 32'(obs_busy), 0);
                end
            end
            if (done_cnt > 0 && (mode == 3 || c >= done_c + 2)) break;
        end
        check("words", n_got, n_exp);
        check("done_pulses", done_cnt, 1);
        check("done_cycle", done_c, (n_exp == 0) ? 1 : last_pop + 1);
        check("busy_seen", 32'(busy_seen), 32'(n_exp != 0));
        $display("sel=%0d run: words=%0d done_cycle=%0d", sel, n_got, done_c);
    endtask

    initial begin
        bit drained;
        #2;
        check("rst_busy", 32'(busy_v[0]), 0);
        check("rst_done", 32'(done_v[0]), 0);
        check("rst_valid", 32'(b4.out_valid), 0);
        check("rst_data", b4.out_data, 0);
        check("rst_addr", 32'(b4.mem_addr), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sel = 0; collect(4, 0, 30);
        sel = 0; collect(4, 1, 40);
        sel = 1; collect(8, 2, 60);
        sel = 3; collect(0, 4, 20);

        sel = 2; collect(3, 3, 40);
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        #1;
        check("restart_from_idle", 32'(obs_busy), 1);
        drained = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (obs_done) begin drained = 1'b1; break; end
        end
        check("second_run_done", 32'(drained), 1);
        @(posedge clk); #2;
        check("idle_after_second", 32'(obs_busy), 0);

        sel = 0;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_full_valid", 32'(obs_valid), 1);
        check("pre_reset_addr", 32'(obs_addr), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", 32'(obs_valid), 0);
        check("mid_reset_busy", 32'(obs_busy), 0);
        check("mid_reset_data", obs_data, 0);
        check("mid_reset_addr", 32'(obs_addr), 0);
        @(negedge clk); rst_n = 1'b1;
        ready_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("idle_after_release", 32'(obs_busy), 0);
        check("empty_after_release", 32'(obs_valid), 0);
        collect(4, 0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_fetch_stage.md
PIPELINED_FETCH_STAGE -- requirements
Module: pipelined_fetch_stage

Interface
REQ-001 Parameter: COUNT, default 30'd8, number of words fetched per run.
REQ-002 Port: clk  input  1  rising-edge clock; all state in this block is clocked by it.
REQ-003 Port: reset  input  1  asynchronous, active-low; reset==0 forces the reset state immediately, independent of clk.
REQ-004 Port: start  input  1  request to begin a run; sampled on clk.
REQ-005 Port: mem_addr  output  30  word index [31:2] driven to the external combinational memory.
REQ-006 Port: mem_data  input  32  read data for mem_addr, valid in the same cycle.
REQ-007 Port: out_data  output  32  word offered downstream to the accumulator stage.
REQ-008 Port: out_valid  output  1  out_data holds a valid word.
REQ-009 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  single-cycle pulse marking the end of a run.

Function
REQ-012 FSM states SHALL be IDLE, FETCH and DRAIN; busy = (state != IDLE).
REQ-013 IDLE + start==1 -> FETCH at the next edge; index cleared to 0 at that edge; start SHALL be ignored outside IDLE.
REQ-014 IDLE + start==1 with COUNT==0 -> stay IDLE; done=1 for exactly the next cycle; no word issued.
REQ-015 mem_addr SHALL equal the 30-bit index register at all times.
REQ-016 Buffer: 2-entry FIFO of 32-bit words; out_valid = (occupancy != 0); out_data = head entry.
REQ-017 Pop: a pop occurs in a cycle where out_valid && out_ready.
REQ-018 Issue: a cycle in FETCH where occupancy < 2, or occupancy == 2 with a pop in that cycle; an issue writes mem_data to the FIFO tail and increments index by 1 (30-bit, mod 2^30) at the edge.
REQ-019 A simultaneous issue and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-020 FETCH -> DRAIN at the edge of the issue with index == COUNT-1; no further issues after that edge.
REQ-021 DRAIN -> IDLE at the edge where the final pop empties the FIFO; done=1 for the cycle following that edge.
REQ-022 If the final pop occurs in the same cycle as the last issue (occupancy 1 -> 1), SHALL go FETCH -> DRAIN normally and complete on the later pop.
REQ-023 Latency: with out_ready held 1, start sampled at edge k gives the first out_valid in the cycle after edge k+1; then one word per cycle; COUNT words in total.
REQ-024 While out_valid && !out_ready, out_data and out_valid SHALL stay stable.
REQ-025 Words SHALL leave in index order 0..COUNT-1 with no loss or duplication under any out_ready pattern.

Reset
REQ-026 reset==0 SHALL force state=IDLE, index=0, occupancy=0, out_valid=0, out_data=0, busy=0, done=0, asynchronously.
REQ-027 Reset mid-run SHALL discard buffered words; after release the block stays in IDLE until a new start.
REQ-028 The first active edge after release (reset 0->1) SHALL be treated as a normal edge.

Verification
REQ-029 COUNT=4, mem_data=idx*3, out_ready=1, start pulse -> out_data 0,3,6,9 on four consecutive cycles; done pulses once, one cycle after the last pop; busy low afterwards.
REQ-030 COUNT=4, out_ready=0 for 5 cycles after start -> occupancy saturates at 2; mem_addr holds 2; out_data holds 0; after out_ready=1, sequence 0,3,6,9 with no loss.
REQ-031 COUNT=8, out_ready toggling 1,0,1,0,... -> all 8 words in order; a simultaneous issue+pop keeps occupancy constant.
REQ-032 start held high across an entire COUNT=3 run -> exactly one run; a new run begins only from IDLE after done.
REQ-033 reset driven 0 mid-edge-period during FETCH with 2 buffered words -> out_valid and busy drop immediately; the next start restarts at mem_addr 0.
REQ-034 COUNT=0, start pulse -> no out_valid; done=1 for exactly one cycle; busy stays 0.
